// File: rtl/run_sequencer.sv
// Multi-run controller: IM load, DM load, execute, DM unload, with memory muxing and DM range snooping.
// Optional execution watchdog enabled by defining RUN_WATCHDOG_EN.
module run_sequencer #(
  parameter int CORE_COUNT          = 1,
  parameter int REG_WIDTH           = 12,
  parameter int DATA_MEM_ADDR_WIDTH = 12,
  parameter int INS_MEM_ADDR_WIDTH  = 8,
  parameter int CYCLE_CNT_WIDTH     = 26,
  parameter int RUN_CNT_WIDTH       = 8,
  parameter int TIMEOUT_CYCLES      = 2**24,
  parameter int Q_END_LOC           = 7,
  parameter int R_START_LOC         = 5,
  parameter int R_END_LOC           = 8,
  localparam int DATA_MEM_WIDTH     = CORE_COUNT*REG_WIDTH
) (
  input  logic                           clk,
  input  logic                           rstN,
  input  logic                           startN,
  input  logic                           reload_imem,
  input  logic                           uart_new_byte_indicate,
  output logic                           new_ins_byte_indicate,
  output logic                           new_data_byte_indicate,
  input  logic                           uart_imem_received,
  input  logic                           uart_dmem_received,
  input  logic                           uart_dmem_transmitted,
  input  logic                           proc_done,
  input  logic [INS_MEM_ADDR_WIDTH-1:0]  uart_imem_addr,
  input  logic                           uart_imem_wr_en,
  input  logic [INS_MEM_ADDR_WIDTH-1:0]  proc_imem_addr,
  input  logic [DATA_MEM_ADDR_WIDTH-1:0] uart_dmem_addr,
  input  logic [DATA_MEM_WIDTH-1:0]      uart_dmem_data,
  input  logic                           uart_dmem_wr_en,
  input  logic [DATA_MEM_ADDR_WIDTH-1:0] proc_dmem_addr,
  input  logic [DATA_MEM_WIDTH-1:0]      proc_dmem_data,
  input  logic                           proc_dmem_wr_en,
  output logic [INS_MEM_ADDR_WIDTH-1:0]  imem_addr,
  output logic                           imem_wr_en,
  output logic [DATA_MEM_ADDR_WIDTH-1:0] dmem_addr,
  output logic [DATA_MEM_WIDTH-1:0]      dmem_data_in,
  output logic                           dmem_wr_en,
  output logic                           proc_startN,
  output logic                           uart_tx_startN,
  output logic [REG_WIDTH-1:0]           rx_end_addr,
  output logic [REG_WIDTH-1:0]           tx_start_addr,
  output logic [REG_WIDTH-1:0]           tx_end_addr,
  output logic [2:0]                     state,
  output logic                           error,
  output logic [CYCLE_CNT_WIDTH-1:0]     cycle_count,
  output logic [RUN_CNT_WIDTH-1:0]       run_count
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOAD_IMEM = 3'd1;
  localparam logic [2:0] S_LOAD_DMEM = 3'd2;
  localparam logic [2:0] S_EXEC      = 3'd4;
  localparam logic [2:0] S_UNLOAD    = 3'd5;
  localparam logic [2:0] S_DONE      = 3'd6;
  localparam logic [2:0] S_ERROR     = 3'd7;

  logic [2:0]                 state_r, next_state_s;
  logic                       startN_d_r, imem_valid_r;
  logic                       start_ok_s, enter_exec_s, enter_unload_s, timeout_s;
  logic                       proc_startN_r, uart_tx_startN_r, error_r;
  logic [CYCLE_CNT_WIDTH-1:0] cycle_count_r;
  logic [RUN_CNT_WIDTH-1:0]   run_count_r;
  logic [REG_WIDTH-1:0]       rx_end_r, tx_start_r, tx_end_r;

  assign start_ok_s     = (startN_d_r & ~startN) &
                          ((state_r == S_IDLE) | (state_r == S_DONE) | (state_r == S_ERROR));
  assign enter_exec_s   = (next_state_s == S_EXEC) & (state_r != S_EXEC);
  assign enter_unload_s = (next_state_s == S_UNLOAD) & (state_r != S_UNLOAD);

`ifdef RUN_WATCHDOG_EN
  localparam logic [CYCLE_CNT_WIDTH-1:0] TIMEOUT_LAST = CYCLE_CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  assign timeout_s = (cycle_count_r == TIMEOUT_LAST);
`else
  logic unused_timeout_s;
  assign unused_timeout_s = (TIMEOUT_CYCLES != 0);
  assign timeout_s        = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; proc_done takes priority over a same-cycle timeout
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start_ok_s) begin
          next_state_s = (reload_imem | ~imem_valid_r) ? S_LOAD_IMEM : S_LOAD_DMEM;
        end else begin
          next_state_s = state_r;
        end
      end
      S_LOAD_IMEM: next_state_s = uart_imem_received    ? S_LOAD_DMEM : S_LOAD_IMEM;
      S_LOAD_DMEM: next_state_s = uart_dmem_received    ? S_EXEC      : S_LOAD_DMEM;
      S_EXEC:      next_state_s = proc_done ? S_UNLOAD : (timeout_s ? S_ERROR : S_EXEC);
      S_UNLOAD:    next_state_s = uart_dmem_transmitted ? S_DONE      : S_UNLOAD;
      default:     next_state_s = S_IDLE;
    endcase
  end

  // Start-edge detect, one-cycle start strobes, error flag and image-valid tracking
  always_ff @(posedge clk) begin
    if (!rstN) begin
      startN_d_r       <= 1'b1;
      imem_valid_r     <= 1'b0;
      proc_startN_r    <= 1'b1;
      uart_tx_startN_r <= 1'b1;
      error_r          <= 1'b0;
    end else begin
      startN_d_r       <= startN;
      proc_startN_r    <= ~enter_exec_s;
      uart_tx_startN_r <= ~enter_unload_s;
      if ((state_r == S_LOAD_IMEM) && uart_imem_received) imem_valid_r <= 1'b1;
      if (start_ok_s) begin
        error_r <= 1'b0;
      end else if ((state_r == S_EXEC) && (next_state_s == S_ERROR)) begin
        error_r <= 1'b1;
      end
    end
  end

  // Saturating execute-cycle counter and wrapping completed-run counter
  always_ff @(posedge clk) begin
    if (!rstN) begin
      cycle_count_r <= '0;
      run_count_r   <= '0;
    end else begin
      if (enter_exec_s) begin
        cycle_count_r <= '0;
      end else if ((state_r == S_EXEC) && (cycle_count_r != '1)) begin
        cycle_count_r <= cycle_count_r + CYCLE_CNT_WIDTH'(1);
      end
      if ((state_r == S_UNLOAD) && uart_dmem_transmitted) begin
        run_count_r <= run_count_r + RUN_CNT_WIDTH'(1);
      end
    end
  end

  // Snoop UART data-memory writes to the address-range locations
  always_ff @(posedge clk) begin
    if (!rstN) begin
      rx_end_r   <= '0;
      tx_start_r <= '0;
      tx_end_r   <= '0;
    end else if ((state_r == S_LOAD_DMEM) && uart_dmem_wr_en) begin
      if (uart_dmem_addr == DATA_MEM_ADDR_WIDTH'(Q_END_LOC))   rx_end_r   <= uart_dmem_data[REG_WIDTH-1:0];
      if (uart_dmem_addr == DATA_MEM_ADDR_WIDTH'(R_START_LOC)) tx_start_r <= uart_dmem_data[REG_WIDTH-1:0];
      if (uart_dmem_addr == DATA_MEM_ADDR_WIDTH'(R_END_LOC))   tx_end_r   <= uart_dmem_data[REG_WIDTH-1:0];
    end
  end

  // Memory muxing and byte-indicate steering from the current state
  always_comb begin
    imem_addr              = '0;
    imem_wr_en             = 1'b0;
    dmem_addr              = '0;
    dmem_data_in           = '0;
    dmem_wr_en             = 1'b0;
    new_ins_byte_indicate  = 1'b0;
    new_data_byte_indicate = 1'b0;
    case (state_r)
      S_LOAD_IMEM: begin
        imem_addr             = uart_imem_addr;
        imem_wr_en            = uart_imem_wr_en;
        new_ins_byte_indicate = uart_new_byte_indicate;
      end
      S_LOAD_DMEM, S_UNLOAD: begin
        dmem_addr              = uart_dmem_addr;
        dmem_data_in           = uart_dmem_data;
        dmem_wr_en             = uart_dmem_wr_en;
        new_data_byte_indicate = uart_new_byte_indicate & (state_r == S_LOAD_DMEM);
      end
      S_EXEC: begin
        imem_addr    = proc_imem_addr;
        dmem_addr    = proc_dmem_addr;
        dmem_data_in = proc_dmem_data;
        dmem_wr_en   = proc_dmem_wr_en;
      end
      default: begin
        imem_addr = '0;
      end
    endcase
  end

  assign state          = state_r;
  assign proc_startN    = proc_startN_r;
  assign uart_tx_startN = uart_tx_startN_r;
  assign error          = error_r;
  assign cycle_count    = cycle_count_r;
  assign run_count      = run_count_r;
  assign rx_end_addr    = rx_end_r;
  assign tx_start_addr  = tx_start_r;
  assign tx_end_addr    = tx_end_r;

endmodule

// File: tb/tb_run_sequencer.sv
// Directed bench for run_sequencer: table-driven second run plus hand-written multi-cycle sequences.
module tb_run_sequencer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstN, startN, reload_imem, uart_new_byte_indicate;
  logic        new_ins_byte_indicate, new_data_byte_indicate;
  logic        uart_imem_received, uart_dmem_received, uart_dmem_transmitted, proc_done;
  logic [7:0]  uart_imem_addr, proc_imem_addr, imem_addr;
  logic        uart_imem_wr_en, imem_wr_en;
  logic [11:0] uart_dmem_addr, uart_dmem_data, proc_dmem_addr, proc_dmem_data;
  logic        uart_dmem_wr_en, proc_dmem_wr_en;
  logic [11:0] dmem_addr, dmem_data_in;
  logic        dmem_wr_en, proc_startN, uart_tx_startN;
  logic [11:0] rx_end_addr, tx_start_addr, tx_end_addr;
  logic [2:0]  state;
  logic        error;
  logic [25:0] cycle_count;
  logic [7:0]  run_count;

  int errors = 0;
  int checks = 0;

  run_sequencer #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rstN(rstN), .startN(startN), .reload_imem(reload_imem),
    .uart_new_byte_indicate(uart_new_byte_indicate),
    .new_ins_byte_indicate(new_ins_byte_indicate), .new_data_byte_indicate(new_data_byte_indicate),
    .uart_imem_received(uart_imem_received), .uart_dmem_received(uart_dmem_received),
    .uart_dmem_transmitted(uart_dmem_transmitted), .proc_done(proc_done),
    .uart_imem_addr(uart_imem_addr), .uart_imem_wr_en(uart_imem_wr_en), .proc_imem_addr(proc_imem_addr),
    .uart_dmem_addr(uart_dmem_addr), .uart_dmem_data(uart_dmem_data), .uart_dmem_wr_en(uart_dmem_wr_en),
    .proc_dmem_addr(proc_dmem_addr), .proc_dmem_data(proc_dmem_data), .proc_dmem_wr_en(proc_dmem_wr_en),
    .imem_addr(imem_addr), .imem_wr_en(imem_wr_en), .dmem_addr(dmem_addr),
    .dmem_data_in(dmem_data_in), .dmem_wr_en(dmem_wr_en), .proc_startN(proc_startN),
    .uart_tx_startN(uart_tx_startN), .rx_end_addr(rx_end_addr), .tx_start_addr(tx_start_addr),
    .tx_end_addr(tx_end_addr), .state(state), .error(error),
    .cycle_count(cycle_count), .run_count(run_count)
  );

  typedef struct {
    logic        startn, imem_rcv, dmem_rcv, pdone, txd;
    logic        uwr;
    logic [11:0] uaddr, udata;
    logic        pwr;
    logic [11:0] paddr, pdata;
    logic [2:0]  st;
    logic        psn, txn;
    logic [11:0] daddr;
    logic        dwe;
    logic [11:0] ddata, rx_end, tx_start, tx_end;
    logic [7:0]  runs;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    startN = 1'b1; reload_imem = 1'b0; uart_new_byte_indicate = 1'b0;
    uart_imem_received = 1'b0; uart_dmem_received = 1'b0; uart_dmem_transmitted = 1'b0; proc_done = 1'b0;
    uart_imem_addr = 8'h00; uart_imem_wr_en = 1'b0; proc_imem_addr = 8'h00;
    uart_dmem_addr = 12'h000; uart_dmem_data = 12'h000; uart_dmem_wr_en = 1'b0;
    proc_dmem_addr = 12'h000; proc_dmem_data = 12'h000; proc_dmem_wr_en = 1'b0;
  endtask

  task automatic pulse(input int which);
    case (which)
      0: uart_imem_received = 1'b1;
      1: uart_dmem_received = 1'b1;
      2: proc_done = 1'b1;
      default: uart_dmem_transmitted = 1'b1;
    endcase
    step();
    uart_imem_received = 1'b0; uart_dmem_received = 1'b0; proc_done = 1'b0; uart_dmem_transmitted = 1'b0;
  endtask

  initial begin
    int lows;
    int bad;
    idle_inputs();
    rstN = 1'b0;
    step(); step();
    chk("reset_state", state, 3'd0);
    chk("reset_proc_startN", proc_startN, 1'b1);
    chk("reset_tx_startN", uart_tx_startN, 1'b1);
    chk("reset_error", error, 1'b0);
    chk("reset_cycle", cycle_count, 26'd0);
    chk("reset_runs", run_count, 8'd0);
    chk("reset_ranges", {rx_end_addr, tx_start_addr, tx_end_addr}, 36'h0);

    // IDLE: both memories idle regardless of UART inputs
    rstN = 1'b1;
    uart_dmem_wr_en = 1'b1; uart_dmem_addr = 12'h055; uart_imem_wr_en = 1'b1; uart_new_byte_indicate = 1'b1;
    #1;
    chk("idle_dwe", dmem_wr_en, 1'b0);
    chk("idle_daddr", dmem_addr, 12'h000);
    chk("idle_iwe", imem_wr_en, 1'b0);
    chk("idle_ins_ind", new_ins_byte_indicate, 1'b0);
    idle_inputs();

    // Run 1: full flow with instruction load and a 100-cycle execute
    startN = 1'b0; step();
    chk("r1_load_imem", state, 3'd1);
    startN = 1'b1; uart_imem_wr_en = 1'b1; uart_imem_addr = 8'h3C; uart_new_byte_indicate = 1'b1;
    #1;
    chk("r1_iwe", imem_wr_en, 1'b1);
    chk("r1_iaddr", imem_addr, 8'h3C);
    chk("r1_ins_ind", {new_ins_byte_indicate, new_data_byte_indicate}, 2'b10);
    idle_inputs();
    pulse(0);
    chk("r1_load_dmem", state, 3'd2);
    uart_new_byte_indicate = 1'b1; #1;
    chk("r1_data_ind", {new_ins_byte_indicate, new_data_byte_indicate}, 2'b01);
    uart_new_byte_indicate = 1'b0;
    pulse(1);
    chk("r1_exec", state, 3'd4);
    chk("r1_proc_startN", proc_startN, 1'b0);
    chk("r1_cycle0", cycle_count, 26'd0);
    proc_imem_addr = 8'h42; #1;
    chk("r1_exec_iaddr", imem_addr, 8'h42);
    lows = 0;
    for (int i = 0; i < 99; i++) begin
      step();
      if (proc_startN == 1'b0) lows++;
    end
    chk("r1_startN_once", lows, 0);
    chk("r1_cycle99", cycle_count, 26'd99);
    pulse(2);
    chk("r1_unload", state, 3'd5);
    chk("r1_cycle100", cycle_count, 26'd100);
    chk("r1_tx_low", uart_tx_startN, 1'b0);
    step();
    chk("r1_tx_high", uart_tx_startN, 1'b1);
    chk("r1_cycle_held", cycle_count, 26'd100);
    pulse(3);
    chk("r1_done", state, 3'd6);
    chk("r1_runs", run_count, 8'd1);

    // Run 2 without IM reload: snooping and memory muxing
    tbl[0] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,12'h000,12'h000, 1'b0,12'h000,12'h000,
               3'd2,1'b1,1'b1, 12'h000,1'b0,12'h000, 12'h000,12'h000,12'h000, 8'd1};
    tbl[1] = '{1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,12'h005,12'h010, 1'b0,12'h000,12'h000,
               3'd2,1'b1,1'b1, 12'h005,1'b1,12'h010, 12'h000,12'h010,12'h000, 8'd1};
    tbl[2] = '{1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,12'h007,12'h00F, 1'b0,12'h000,12'h000,
               3'd2,1'b1,1'b1, 12'h007,1'b1,12'h00F, 12'h00F,12'h010,12'h000, 8'd1};
    tbl[3] = '{1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,12'h008,12'h01F, 1'b0,12'h000,12'h000,
               3'd2,1'b1,1'b1, 12'h008,1'b1,12'h01F, 12'h00F,12'h010,12'h01F, 8'd1};
    tbl[4] = '{1'b1,1'b0,1'b1,1'b0,1'b0, 1'b0,12'h000,12'h000, 1'b1,12'h123,12'h000,
               3'd4,1'b0,1'b1, 12'h123,1'b1,12'h000, 12'h00F,12'h010,12'h01F, 8'd1};
    tbl[5] = '{1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,12'h005,12'hAAA, 1'b1,12'h005,12'h777,
               3'd4,1'b1,1'b1, 12'h005,1'b1,12'h777, 12'h00F,12'h010,12'h01F, 8'd1};
    tbl[6] = '{1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,12'h007,12'hAAA, 1'b1,12'h007,12'h777,
               3'd4,1'b1,1'b1, 12'h007,1'b1,12'h777, 12'h00F,12'h010,12'h01F, 8'd1};
    tbl[7] = '{1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,12'h008,12'hAAA, 1'b1,12'h008,12'h777,
               3'd4,1'b1,1'b1, 12'h008,1'b1,12'h777, 12'h00F,12'h010,12'h01F, 8'd1};
    tbl[8] = '{1'b1,1'b0,1'b0,1'b1,1'b0, 1'b0,12'h0AB,12'h000, 1'b0,12'h000,12'h000,
               3'd5,1'b1,1'b0, 12'h0AB,1'b0,12'h000, 12'h00F,12'h010,12'h01F, 8'd1};
    tbl[9] = '{1'b1,1'b0,1'b0,1'b0,1'b1, 1'b0,12'h0AB,12'h000, 1'b0,12'h000,12'h000,
               3'd6,1'b1,1'b1, 12'h000,1'b0,12'h000, 12'h00F,12'h010,12'h01F, 8'd2};
    for (int i = 0; i < 10; i++) begin
      startN = tbl[i].startn; uart_imem_received = tbl[i].imem_rcv; uart_dmem_received = tbl[i].dmem_rcv;
      proc_done = tbl[i].pdone; uart_dmem_transmitted = tbl[i].txd;
      uart_dmem_wr_en = tbl[i].uwr; uart_dmem_addr = tbl[i].uaddr; uart_dmem_data = tbl[i].udata;
      proc_dmem_wr_en = tbl[i].pwr; proc_dmem_addr = tbl[i].paddr; proc_dmem_data = tbl[i].pdata;
      step();
      chk($sformatf("v%0d_state", i), state, tbl[i].st);
      chk($sformatf("v%0d_startNs", i), {proc_startN, uart_tx_startN}, {tbl[i].psn, tbl[i].txn});
      chk($sformatf("v%0d_dmem", i), {dmem_wr_en, dmem_addr, dmem_data_in}, {tbl[i].dwe, tbl[i].daddr, tbl[i].ddata});
      chk($sformatf("v%0d_ranges", i), {rx_end_addr, tx_start_addr, tx_end_addr},
          {tbl[i].rx_end, tbl[i].tx_start, tbl[i].tx_end});
      chk($sformatf("v%0d_runs", i), run_count, tbl[i].runs);
    end
    idle_inputs();

    // Forced IM reload from DONE
    startN = 1'b0; reload_imem = 1'b1; step();
    chk("reload_imem", state, 3'd1);
    idle_inputs();

    // startN held low across a whole run: exactly one start event
    rstN = 1'b0; step(); rstN = 1'b1; step();
    chk("rst_idle", state, 3'd0);
    startN = 1'b0; step();
    chk("hold_load_imem", state, 3'd1);
    pulse(0); pulse(1); pulse(2); pulse(3);
    chk("hold_done", state, 3'd6);
    bad = 0;
    for (int i = 0; i < 45; i++) begin
      step();
      if (state != 3'd6) bad++;
    end
    chk("hold_no_restart", bad, 0);
    chk("hold_runs", run_count, 8'd1);
    startN = 1'b1; step();

    // Reset during EXEC, then image must be reloaded
    startN = 1'b0; step();
    chk("rerun_load_dmem", state, 3'd2);
    startN = 1'b1;
    pulse(1); step(); step(); step();
    chk("rerun_cycle3", cycle_count, 26'd3);
    rstN = 1'b0; step(); rstN = 1'b1;
    chk("midrst_state", state, 3'd0);
    chk("midrst_outs", {proc_startN, uart_tx_startN, error}, 3'b110);
    chk("midrst_counts", {cycle_count, run_count}, 34'h0);
    startN = 1'b0; step();
    chk("midrst_imem_invalid", state, 3'd1);
    startN = 1'b1;

`ifdef RUN_WATCHDOG_EN
    pulse(0); pulse(1);
    for (int i = 0; i < 15; i++) step();
    chk("wd_before", state, 3'd4);
    step();
    chk("wd_error_state", state, 3'd7);
    chk("wd_error_flag", error, 1'b1);
    uart_dmem_wr_en = 1'b1; #1;
    chk("wd_error_mux", dmem_wr_en, 1'b0);
    uart_dmem_wr_en = 1'b0;
    startN = 1'b0; step();
    chk("wd_restart", {state, error}, {3'd2, 1'b0});
    startN = 1'b1;
    pulse(1);
    for (int i = 0; i < 15; i++) step();
    pulse(2);
    chk("wd_done_wins", {state, error}, {3'd5, 1'b0});
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
